// File: rtl/decode_regfile_if.sv
// decode_regfile_if
//   Bundles every signal of the issue stage except clock and reset.
//   Instruction side : instr, instr_valid -> stage ; instr_ready <- stage
//   Writeback side   : wb_en, wb_addr, wb_data -> stage
//   ALU side         : in1, in2, shamt, opcode, constant, rd_out,
//                      out_valid, illegal <- stage ; out_ready -> stage
//   The master modport drives instructions, writebacks and out_ready
//   (fetch/ALU/testbench side); the slave modport is the issue stage.
interface decode_regfile_if;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] in1;
  logic [31:0] in2;
  logic [4:0]  shamt;
  logic [5:0]  opcode;
  logic [15:0] constant;
  logic [4:0]  rd_out;
  logic        out_valid;
  logic        out_ready;
  logic        illegal;

  modport master (
    output instr, instr_valid, wb_en, wb_addr, wb_data, out_ready,
    input  instr_ready, in1, in2, shamt, opcode, constant, rd_out,
           out_valid, illegal
  );

  modport slave (
    input  instr, instr_valid, wb_en, wb_addr, wb_data, out_ready,
    output instr_ready, in1, in2, shamt, opcode, constant, rd_out,
           out_valid, illegal
  );
endinterface

// File: rtl/decode_regfile.sv
// decode_regfile
//   Issue stage in front of the ALU. Decodes 32-bit instruction words,
//   reads operands from a 32x32 register file (r0 hardwired to zero) with
//   same-cycle writeback bypass, and tracks outstanding destination writes
//   in a pending scoreboard that stalls issue on RAW/WAW hazards.
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous active-high reset
//     bus  - decode_regfile_if.slave (instruction handshake, writeback,
//            registered ALU operands with valid/ready)
module decode_regfile (
  input logic             clk,
  input logic             rst,
  decode_regfile_if.slave bus
);

  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;

  logic        isLegal;
  logic        useRs;
  logic        useRt;
  logic [4:0]  dest;

  logic [31:0] regFile_q [0:31];
  logic [31:0] rsData;
  logic [31:0] rtData;
  logic        wbWrite;

  logic [31:1] pending_q;
  logic [31:1] pending_d;
  logic [31:0] clearVec;
  logic [31:0] livePending;
  logic        hazard;

  logic        transfer;
  logic        legalXfer;
  logic        illegalXfer;

  logic [31:0] in1_q;
  logic [31:0] in2_q;
  logic [4:0]  shamt_q;
  logic [5:0]  opcode_q;
  logic [15:0] constant_q;
  logic [4:0]  rdOut_q;
  logic        outValid_q;
  logic        illegal_q;

  assign op = bus.instr[31:26];
  assign rs = bus.instr[25:21];
  assign rt = bus.instr[20:16];
  assign rd = bus.instr[15:11];

  // Per-opcode operand usage. Immediate forms (addi, load constant) write
  // rt rather than rd; anything above 7 is undefined.
  always_comb begin
    isLegal = 1'b0;
    useRs   = 1'b0;
    useRt   = 1'b0;
    dest    = 5'd0;
    case (op)
      6'd0, 6'd3, 6'd4, 6'd5: begin
        isLegal = 1'b1;
        useRs   = 1'b1;
        useRt   = 1'b1;
        dest    = rd;
      end
      6'd1, 6'd2: begin
        isLegal = 1'b1;
        useRs   = 1'b1;
        dest    = rd;
      end
      6'd6: begin
        isLegal = 1'b1;
        useRs   = 1'b1;
        dest    = rt;
      end
      6'd7: begin
        isLegal = 1'b1;
        dest    = rt;
      end
      default: begin
        isLegal = 1'b0;
      end
    endcase
  end

  // Writes to r0 are dropped here, so entry 0 stays at its reset value of
  // zero and the bypass below can never forward a value for r0.
  assign wbWrite = bus.wb_en && (bus.wb_addr != 5'd0);

  // Combinational read with same-cycle bypass of the incoming writeback,
  // which lets a dependent op issue in the very cycle its producer retires.
  always_comb begin
    rsData = regFile_q[rs];
    rtData = regFile_q[rt];
    if (wbWrite && (bus.wb_addr == rs)) rsData = bus.wb_data;
    if (wbWrite && (bus.wb_addr == rt)) rtData = bus.wb_data;
  end

  // Register file storage; reset clears every entry including r0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regFile_q[i] <= 32'd0;
    end else if (wbWrite) begin
      regFile_q[bus.wb_addr] <= bus.wb_data;
    end
  end

  // A pending bit that this cycle's writeback clears no longer blocks issue.
  assign clearVec    = wbWrite ? (32'd1 << bus.wb_addr) : 32'd0;
  assign livePending = {pending_q, 1'b0} & ~clearVec;

  assign hazard = bus.instr_valid && isLegal &&
                  ((useRs && livePending[rs]) ||
                   (useRt && livePending[rt]) ||
                   livePending[dest]);

  assign bus.instr_ready = !hazard && (!outValid_q || bus.out_ready);
  assign transfer        = bus.instr_valid && bus.instr_ready;
  assign legalXfer       = transfer && isLegal;
  assign illegalXfer     = transfer && !isLegal;

  // Scoreboard update: the issue-time set is applied after the writeback
  // clear so that a collision on the same register leaves it pending.
  always_comb begin
    pending_d = pending_q;
    for (int i = 1; i < 32; i++) begin
      pending_d[i] = (pending_q[i] && !(wbWrite && (bus.wb_addr == 5'(i)))) ||
                     (legalXfer && (dest == 5'(i)));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end

  // ALU output register. Loads on every legal transfer, drops valid once
  // consumed with nothing new behind it, and otherwise holds steady.
  // Illegal words only raise the one-cycle illegal flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in1_q      <= 32'd0;
      in2_q      <= 32'd0;
      shamt_q    <= 5'd0;
      opcode_q   <= 6'd0;
      constant_q <= 16'd0;
      rdOut_q    <= 5'd0;
      outValid_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      illegal_q <= illegalXfer;
      if (legalXfer) begin
        in1_q      <= (op == 6'd7) ? 32'd0 : rsData;
        in2_q      <= useRt ? rtData : 32'd0;
        shamt_q    <= bus.instr[10:6];
        opcode_q   <= op;
        constant_q <= bus.instr[15:0];
        rdOut_q    <= dest;
        outValid_q <= 1'b1;
      end else if (bus.out_ready) begin
        outValid_q <= 1'b0;
      end
    end
  end

  assign bus.in1       = in1_q;
  assign bus.in2       = in2_q;
  assign bus.shamt     = shamt_q;
  assign bus.opcode    = opcode_q;
  assign bus.constant  = constant_q;
  assign bus.rd_out    = rdOut_q;
  assign bus.out_valid = outValid_q;
  assign bus.illegal   = illegal_q;

endmodule

// File: doc/decode_regfile.md
# decode_regfile

Issue stage that sits directly upstream of the ALU. It accepts 32-bit instruction words over a valid/ready handshake, decodes them, and reads source operands from a 32x32 register file. Writeback results from the ALU are bypassed to the read ports. It presents registered `in1`/`in2`/`shamt`/`opcode`/`constant` to the ALU together with the destination register, and a per-register pending scoreboard stalls issue while a source or destination write is outstanding.

## Interface
Parameters:
- None; all widths are fixed by the ALU contract: 32-bit data, 6-bit opcode, 5-bit shamt, 16-bit constant.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `instr`  in  32  instruction word
- `instr_valid`  in  1  `instr` is valid
- `instr_ready`  out  1  stage accepts `instr` this cycle
- `wb_en`  in  1  ALU result writeback strobe
- `wb_addr`  in  5  writeback register index
- `wb_data`  in  32  writeback value (ALU `ans`)
- `in1`  out  32  operand 1 to ALU
- `in2`  out  32  operand 2 to ALU
- `shamt`  out  5  shift amount
- `opcode`  out  6  ALU opcode
- `constant`  out  16  immediate
- `rd_out`  out  5  destination register for this op
- `out_valid`  out  1  ALU inputs valid
- `out_ready`  in  1  downstream consumes the current op
- `illegal`  out  1  one-cycle pulse when an undefined opcode is dropped

## Operation
Field decode:
- `opcode` = `instr[31:26]`, `rs` = `[25:21]`, `rt` = `[20:16]`, `rd` = `[15:11]`, `shamt` = `[10:6]`, `constant` = `[15:0]`.

Per-opcode usage (source registers / destination):
- Opcodes 0, 3, 4, 5 (add, or, and, mul): sources `rs` and `rt`; destination `rd`.
- Opcodes 1, 2 (shl, shr): source `rs`; destination `rd`; `in2` = 0.
- Opcode 6 (addi): source `rs`; destination `rt`; `in2` = 0.
- Opcode 7 (load constant): no sources; destination `rt`; `in1` = `in2` = 0.
- Opcodes 8–63: illegal. The word is accepted, no op is issued, `illegal` pulses on the next cycle, and no scoreboard change is made.

Register file:
- r0 always reads 0 and writes to it are ignored.
- `wb_en` writes `wb_data` into `wb_addr` at the clock edge.
- Reads are combinational. When `wb_en` is high and `wb_addr` equals the source index (and is non-zero), the read returns `wb_data` (same-cycle bypass).

Scoreboard:
- `pending[31:1]` holds one bit per register; r0 is never pending.
- Issuing an op sets `pending[dest]`.
- `wb_en` clears `pending[wb_addr]`.
- If a set and a clear hit the same index in one cycle, the set wins.

Hazard:
- `hazard` is high when any used source, or the destination, is pending and is not being cleared by this cycle's `wb_en`/`wb_addr`.

Handshake:
- `instr_ready` = `!hazard && (!out_valid || out_ready)`. Its hazard term is evaluated on the presented `instr` (only when `instr_valid` is high).
- A transfer occurs when `instr_valid && instr_ready`.
- A legal transfer loads the output register and sets `out_valid`.
- If `out_valid && out_ready` and there is no new legal transfer, `out_valid` clears.
- Outputs hold stable while `out_valid && !out_ready`.

## Timing
Reset (asynchronous, `rst`=1):
- All registers read as 0, all `pending` bits are 0, `out_valid` = 0, `illegal` = 0.
- `in1`, `in2`, `shamt`, `opcode`, `constant`, `rd_out` = 0.
- Any held op is discarded. A writeback presented while `rst` is high is ignored.

Latency and throughput:
- A legal instruction accepted at edge N appears on the outputs with `out_valid` = 1 after edge N.
- Back-to-back issue sustains 1 op/cycle when there is no hazard and `out_ready` = 1.

Dependent ops:
- A dependent op stalls until the cycle in which the producer's `wb_en` appears.
- It issues in that same cycle, using the bypassed value. The minimum producer-to-consumer gap is therefore zero cycles after writeback.

Boundary cases:
- Illegal opcode while `out_valid && !out_ready`: the word is not accepted (`instr_ready` = 0).
- `wb_en` with `wb_addr` = 0: no effect.
- `wb_en` to a non-pending register: data is written; the scoreboard is unchanged.

## Test plan
- **Reset then writeback.** Apply reset, then `wb_en`/`wb_addr`=3/`wb_data`=0x10. Issue add rs=3 rt=0 rd=4 -> next cycle `in1`=0x10, `in2`=0, `opcode`=0, `rd_out`=4, `out_valid`=1; `pending[4]`=1.
- **RAW stall and bypass.** Issue add rd=5, then or rs=5. The or is held with `instr_ready`=0 until `wb_en`/`wb_addr`=5/`wb_data`=0xABCD. In that cycle the or is accepted -> `in1`=0xABCD next cycle.
- **Immediate decode.** Issue opcode 6 rs=0 rt=7 constant=0x1234 -> `opcode`=6, `constant`=0x1234, `rd_out`=7. Issue opcode 7 -> `in1`=`in2`=0.
- **Backpressure.** Hold `out_ready`=0 with `out_valid`=1 -> `instr_ready`=0 and the outputs are unchanged for 3 cycles. Raise `out_ready` -> the next op is issued the following edge.
- **Illegal opcode.** Present opcode 9 -> accepted; `illegal`=1 for exactly one cycle; `out_valid` stays 0; `pending` unchanged.
- **Reset mid-stall.** Set `pending[5]`, present a dependent op, then pulse `rst` -> `out_valid`=0, `pending`=0, and the same op is then accepted immediately with `in1`=0.
